// File: rtl/bcd_pkg.sv
// Shared BCD constants, types and helpers for the scanned BCD counter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX   = 4'd9;
    localparam bcd_digit_t BCD_BLANK = 4'hF;

    // True when both nibbles of a two-digit BCD value are legal decimal digits.
    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0..9) up/down counter with clear, load and carry/borrow out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t digit,
    output logic       carry_c
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    // Next digit: clear beats load beats step; decade wraps 9->0 up, 0->9 down.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (load) begin
            digit_d = load_digit;
        end else if (step) begin
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + DIGIT_W'(1);
            end else begin
                digit_d = (digit_q == '0) ? BCD_MAX : digit_q - DIGIT_W'(1);
            end
        end
    end

    // Carry on the up edge of 9, borrow on the down edge of 0.
    always_comb begin
        carry_c = up ? (digit_q == BCD_MAX) : (digit_q == '0);
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_counter_scan.sv
// Two-digit BCD up/down counter (0..TOP) with prescaled stepping and a
// two-slot digit scanner feeding a 7-segment decoder.
module bcd_counter_scan
    import bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV = 50_000,
    parameter int unsigned TOP      = 99,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count_bcd,
    output logic       tc,
    output logic [3:0] scan_bcd,
    output logic [1:0] scan_sel
);

    localparam int unsigned PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [7:0] TOP_BCD = {4'(TOP / 10), 4'(TOP % 10)};

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        scan_sel_q, scan_sel_d;
    logic              tc_q, tc_d;

    logic       step_c;
    logic       load_ok_c;
    logic       dig_clr_c;
    logic       dig_load_c;
    logic [7:0] dig_load_val_c;
    logic       dig_step_c;
    logic       units_carry_c;
    logic       tens_carry_c;
    bcd_digit_t units;
    bcd_digit_t tens;

    assign count_bcd = {tens, units};
    assign step_c    = en && (presc_q == PRE_MAX);
    assign load_ok_c = bcd_valid(load_val) && (load_val <= TOP_BCD);

    // Prescaler: runs only while enabled, restarts on clear or any load.
    always_comb begin
        presc_d = presc_q;
        if (clr || load) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + PRE_W'(1);
        end
    end

    // Digit controls and terminal count: clr > load > step, TOP wrap handled here.
    always_comb begin
        dig_clr_c      = 1'b0;
        dig_load_c     = 1'b0;
        dig_load_val_c = load_val;
        dig_step_c     = 1'b0;
        tc_d           = 1'b0;
        if (clr) begin
            dig_clr_c = 1'b1;
        end else if (load) begin
            dig_load_c = load_ok_c;
        end else if (step_c) begin
            if (up && (count_bcd == TOP_BCD)) begin
                dig_clr_c = 1'b1;
                tc_d      = 1'b1;
            end else if (!up && (count_bcd == 8'h00)) begin
                dig_load_c     = 1'b1;
                dig_load_val_c = TOP_BCD;
                tc_d           = 1'b1;
            end else begin
                dig_step_c = 1'b1;
            end
        end
    end

    // Free-running scan slot timer; swaps the active digit at the end of a slot.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_sel_d = scan_sel_q;
        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            scan_sel_d = {scan_sel_q[0], scan_sel_q[1]};
        end
    end

    // Displayed digit, with optional leading-zero blanking of the tens slot.
    always_comb begin
        scan_bcd = units;
        if (scan_sel_q[1]) begin
            scan_bcd = (BLANK_LZ && (tens == '0)) ? BCD_BLANK : tens;
        end
    end

    // Prescaler, scanner and terminal-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            scan_cnt_q <= '0;
            scan_sel_q <= 2'b01;
            tc_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            scan_cnt_q <= scan_cnt_d;
            scan_sel_q <= scan_sel_d;
            tc_q       <= tc_d;
        end
    end

    assign tc       = tc_q;
    assign scan_sel = scan_sel_q;

    bcd_digit u_units (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (dig_clr_c),
        .load       (dig_load_c),
        .load_digit (dig_load_val_c[3:0]),
        .step       (dig_step_c),
        .up         (up),
        .digit      (units),
        .carry_c    (units_carry_c)
    );

    bcd_digit u_tens (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (dig_clr_c),
        .load       (dig_load_c),
        .load_digit (dig_load_val_c[7:4]),
        .step       (dig_step_c && units_carry_c),
        .up         (up),
        .digit      (tens),
        .carry_c    (tens_carry_c)
    );

    // Tens borrow/carry is not needed: the TOP wrap is decided above.
    logic unused_c;
    assign unused_c = tens_carry_c;

endmodule

// File: doc/bcd_counter_scan.md
Name: bcd_counter_scan

Overview:
- Two-digit BCD up/down counter (00..TOP) advanced by an internal prescaled tick.
- Time-multiplexes its two digits onto one 4-bit BCD bus with a digit-select strobe.
- Sits directly upstream of the team's 7-segment decoder, which consumes scan_bcd.
- Provides clear, parallel load, enable, direction and a terminal-count pulse for cascading.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per count step; must be ≥2.
- SCAN_DIV, 50_000: clk cycles per display digit slot; must be ≥2.
- TOP, 99: maximum count (decimal 1..99); count range is 0..TOP.
- BLANK_LZ, 1: 1 = blank the tens digit when it is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; gates prescaler and stepping.
- up  in  1  1 = count up, 0 = count down; sampled on the step cycle.
- clr  in  1  synchronous clear to 00.
- load  in  1  synchronous parallel load.
- load_val  in  8  BCD value; [7:4] tens, [3:0] units.
- count_bcd  out  8  registered current count, BCD.
- tc  out  1  one-cycle pulse on wrap (TOP→0 up, 0→TOP down).
- scan_bcd  out  4  BCD digit currently displayed, or 4'hF for blank.
- scan_sel  out  2  one-hot active-high digit select; 01 = units, 10 = tens.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: count_bcd = 8'h00, tc = 0, prescaler = 0, scan counter = 0, scan_sel = 2'b01.
- Prescaler:
  - When en = 1, counts 0..TICK_DIV-1 and wraps.
  - step is asserted on the cycle the prescaler equals TICK_DIV-1.
  - When en = 0, the prescaler holds its value and no step occurs.
- Priority per cycle: clr > load > step.
  - clr: count = 00, prescaler = 0, tc = 0.
  - load: count = load_val, prescaler = 0, tc = 0.
  - Invalid load (either nibble > 9, or value > TOP): count unchanged. The prescaler is still cleared.
- Step up:
  - If count == TOP: count = 00 and tc = 1 for that cycle.
  - Else units+1; if units was 9, units = 0 and tens+1.
- Step down:
  - If count == 00: count = TOP and tc = 1.
  - Else units-1; if units was 0, units = 9 and tens-1.
- Latency: count_bcd and tc update on the clk edge where step/clr/load is seen. tc is high for exactly one cycle and otherwise 0.
- Scan counter: free-running, independent of en/clr/load. Counts 0..SCAN_DIV-1; at SCAN_DIV-1, scan_sel toggles 01↔10.
- scan_bcd (combinational from registers, no extra latency):
  - scan_sel = 01: count_bcd[3:0].
  - scan_sel = 10: count_bcd[7:4], except 4'hF when BLANK_LZ = 1 and tens == 0. The downstream decoder renders 4'hF as all segments off.
- Output legality: count_bcd is never outside 0..TOP with valid BCD nibbles; scan_sel is never 00 or 11.
- Reset mid-step: rst_n asserted at any time forces reset values immediately, with no tc glitch after release.

Decomposition:
- Package bcd_pkg:
  - constants BCD_MAX = 4'd9 and BCD_BLANK = 4'hF.
  - type bcd_digit_t (logic [3:0]).
  - function bcd_valid(8-bit) returning 1 when both nibbles are ≤ 9.
- Sub-module bcd_digit: one decade counter.
  - Inputs: step, up, load, load digit, clr.
  - Outputs: digit, carry/borrow out (asserted at 9 on up, 0 on down).
  - Instantiated twice: tens stepped by units carry. TOP wrap logic stays in the top level.

Test Plan (TICK_DIV = 4, SCAN_DIV = 3, TOP = 99 unless stated):
- Reset then en = 1, up = 1 for 40 clk → count_bcd steps every 4 clk: 00,01..09,10; no tc.
- load = 1, load_val = 8'h98, then count up → 98, 99, 00 with tc = 1 for exactly one clk on the 99→00 edge.
- Count down from 8'h10 → 09, then …00, 99 with tc = 1; with TOP = 59, 00 → 59 with tc = 1.
- load_val = 8'h3A or 8'hA0 → count_bcd unchanged. clr and load asserted together → 00. en = 0 for 10 clk → count and prescaler frozen.
- Count = 07, BLANK_LZ = 1 → scan_sel alternates 01/10 every 3 clk, scan_bcd 7 / F. With BLANK_LZ = 0 → 7 / 0. Count = 42 → 2 / 4.
- Assert rst_n = 0 mid-prescale and on a wrap cycle → count_bcd = 00, tc = 0, scan_sel = 01 immediately, without waiting for clk.
